// File: rtl/div.sv
// Radix-2 restoring divider that services DIV/DIVU requests from the execute stage.
// It produces one quotient bit per clock. The result is {remainder, quotient}.
// The result is held with ready_o high until the initiator drops start_i.
module div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  // Two's-complement negation, used for operand magnitudes and sign fix-up
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_neg1;
  logic             r_neg2;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // The partial remainder is shifted left by one and picks up the next dividend bit.
  // The dividend MSB sits at the top of r_quo. The trial subtraction is one bit wider
  // than WIDTH, so its top bit tells whether the result went negative.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvsr};

  // Operand magnitudes. An operand is negated only for a signed divide with its MSB set.
  assign w_mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? negate(opdata1_i) : opdata1_i;
  assign w_mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? negate(opdata2_i) : opdata2_i;

  // Sign correction. The quotient follows the sign of dividend XOR divisor.
  // The remainder follows the sign of the dividend.
  assign w_quo_fix = (r_neg1 ^ r_neg2) ? negate(r_quo) : r_quo;
  assign w_rem_fix = r_neg1 ? negate(r_rem) : r_rem;

  // Control FSM and datapath: one iteration per edge while in S_ON
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_rem    <= ZERO_W;
      r_quo    <= ZERO_W;
      r_dvsr   <= ZERO_W;
      r_neg1   <= 1'b0;
      r_neg2   <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= {(2*WIDTH){1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= {(2*WIDTH){1'b0}};
          if (start_i && !annul_i) begin
            if (opdata2_i == ZERO_W) begin
              r_state <= S_BYZERO;
            end else begin
              r_state <= S_ON;
              r_quo   <= w_mag1;
              r_dvsr  <= w_mag2;
              r_neg1  <= signed_div_i & opdata1_i[WIDTH-1];
              r_neg2  <= signed_div_i & opdata2_i[WIDTH-1];
              r_cnt   <= {CW{1'b0}};
              r_rem   <= ZERO_W;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BYZERO: begin
          result_o <= {(2*WIDTH){1'b0}};
          ready_o  <= 1'b0;
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            r_state  <= S_IDLE;
            ready_o  <= 1'b0;
            result_o <= {(2*WIDTH){1'b0}};
          end else if (r_cnt == CNT_LAST) begin
            r_state  <= S_END;
            ready_o  <= 1'b1;
            result_o <= {w_rem_fix, w_quo_fix};
          end else begin
            r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_END: begin
          if (annul_i || !start_i) begin
            r_state  <= S_IDLE;
            ready_o  <= 1'b0;
            result_o <= {(2*WIDTH){1'b0}};
          end else begin
            ready_o <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          ready_o  <= 1'b0;
          result_o <= {(2*WIDTH){1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div. Directed cases and random requests are checked
// against an arithmetic reference model.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_vec;
  int n_err;

  div #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: truncating division on 64-bit integers, with 0 returned for a zero divisor
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue a request and hold start_i high.
  // lat is the index of the first edge after which ready_o is seen high, or -1 if ready_o never rises.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] res);
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    lat = -1; res = 64'd0;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        lat = e; res = result_o;
        break;
      end
    end
  endtask

  // Drop start_i and sample the outputs just after the next edge
  task automatic drop(output logic rdy, output logic [63:0] res);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    rdy = ready_o; res = result_o;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_err++; $display("FAIL reset: ready=%b result=%h want 0/0", ready_o, result_o);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_divu();
    int lat; logic [63:0] res; logic rdy;
    issue(1'b0, 32'd100, 32'd7, lat, res);
    n_vec++;
    if (lat !== 33) begin n_err++; $display("FAIL divu_latency: got %0d want 33", lat); end
    n_vec++;
    if (res !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu_100_7: got %h want %h", res, {32'd2, 32'd14}); end
    drop(rdy, res);
    n_vec++;
    if (rdy !== 1'b0 || res !== 64'd0) begin n_err++; $display("FAIL divu_drop: ready=%b result=%h want 0/0", rdy, res); end
  endtask

  task automatic test_div_signed();
    int lat; logic [63:0] res; logic rdy;
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, lat, res);
    n_vec++;
    if (lat !== 33 || res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_err++; $display("FAIL div_m7_2: lat=%0d res=%h want 33/%h", lat, res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    drop(rdy, res);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, lat, res);
    n_vec++;
    if (lat !== 33 || res !== {32'd1, 32'hFFFF_FFFD}) begin
      n_err++; $display("FAIL div_7_m2: lat=%0d res=%h want 33/%h", lat, res, {32'd1, 32'hFFFF_FFFD});
    end
    drop(rdy, res);
  endtask

  task automatic test_div_by_zero();
    int lat; logic [63:0] res; logic rdy;
    issue(1'b0, 32'd12345, 32'd0, lat, res);
    n_vec++;
    if (lat !== 2 || res !== 64'd0) begin n_err++; $display("FAIL divu_by_zero: lat=%0d res=%h want 2/0", lat, res); end
    drop(rdy, res);
    issue(1'b1, 32'h8000_0001, 32'd0, lat, res);
    n_vec++;
    if (lat !== 2 || res !== 64'd0) begin n_err++; $display("FAIL div_by_zero: lat=%0d res=%h want 2/0", lat, res); end
    drop(rdy, res);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
    n_vec++;
    if (lat !== 33 || res !== {32'd0, 32'h8000_0000}) begin
      n_err++; $display("FAIL div_overflow: lat=%0d res=%h want 33/%h", lat, res, {32'd0, 32'h8000_0000});
    end
    drop(rdy, res);
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res; logic rdy; logic seen;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin n_err++; $display("FAIL annul_edge: ready=%b result=%h want 0/0", ready_o, result_o); end
    @(negedge clk); annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) seen = 1'b1; end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL annul_no_ready: ready seen=%b want 0", seen); end
    issue(1'b0, 32'd9, 32'd3, lat, res);
    n_vec++;
    if (lat !== 33 || res !== {32'd0, 32'd3}) begin n_err++; $display("FAIL annul_then_9_3: lat=%0d res=%h want 33/%h", lat, res, {32'd0, 32'd3}); end
    drop(rdy, res);
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] res; logic rdy;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin n_err++; $display("FAIL reset_mid: ready=%b result=%h want 0/0", ready_o, result_o); end
    @(negedge clk); rst = 1'b1;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
    n_vec++;
    if (lat !== 33 || res !== {32'd0, 32'd1}) begin n_err++; $display("FAIL reset_then_ff_ff: lat=%0d res=%h want 33/%h", lat, res, {32'd0, 32'd1}); end
    drop(rdy, res);
  endtask

  task automatic test_hold_end();
    int lat; logic [63:0] res; logic rdy; logic bad; logic seen;
    issue(1'b0, 32'd50, 32'd6, lat, res);
    n_vec++;
    if (lat !== 33 || res !== {32'd2, 32'd8}) begin n_err++; $display("FAIL hold_first: lat=%0d res=%h want 33/%h", lat, res, {32'd2, 32'd8}); end
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd8}) bad = 1'b1;
    end
    n_vec++;
    if (bad !== 1'b0) begin n_err++; $display("FAIL hold_stable: ready=%b result=%h want 1/%h", ready_o, result_o, {32'd2, 32'd8}); end
    drop(rdy, res);
    n_vec++;
    if (rdy !== 1'b0 || res !== 64'd0) begin n_err++; $display("FAIL hold_drop: ready=%b result=%h want 0/0", rdy, res); end
    // With annul_i high in IDLE, a pending start_i is not accepted
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b1; opdata1_i = 32'd8; opdata2_i = 32'd0;
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (ready_o) seen = 1'b1; end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL annul_idle: ready seen=%b want 0", seen); end
    @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [63:0] res, exp_res; logic rdy;
    logic s; logic [31:0] a, b;
    for (int k = 0; k < 24; k++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom();
      case (k % 4)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 255));
        2: b = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        default: b = $urandom();
      endcase
      exp_res = ref_div(s, a, b);
      exp_lat = (b == 32'd0) ? 2 : 33;
      issue(s, a, b, lat, res);
      n_vec++;
      if (lat !== exp_lat || res !== exp_res) begin
        n_err++; $display("FAIL random s=%b %h/%h: lat=%0d res=%h want %0d/%h", s, a, b, lat, res, exp_lat, exp_res);
      end
      drop(rdy, res);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    test_reset();
    test_divu();
    test_div_signed();
    test_div_by_zero();
    test_annul();
    test_reset_mid();
    test_hold_end();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle iterative divider that services DIV/DIVU requests issued by the execute stage.
- The execute stage is the initiator: it raises start with operands and holds them steady; this block computes and returns {remainder, quotient} with a ready flag.
- The execute stage writes the returned result to HI/LO.
- Radix-2 restoring algorithm, one quotient bit per cycle, no combinational divider.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low; rst==0 at a rising edge resets the block.
- signed_div_i  input  1  1 = DIV (two's-complement), 0 = DIVU; sampled with start_i.
- opdata1_i  input  WIDTH  dividend; held stable by the initiator while start_i=1.
- opdata2_i  input  WIDTH  divisor; held stable by the initiator while start_i=1.
- start_i  input  1  request; held high by the initiator until it has seen ready_o=1.
- annul_i  input  1  cancel (e.g. flush); aborts any operation in progress.
- result_o  output  2*WIDTH  [2W-1:W] = remainder, [W-1:0] = quotient.
- ready_o  output  1  result valid.

Behaviour:
- All outputs and state are registered.
- Reset (rst==0 at an edge): state=IDLE, ready_o=0, result_o=0, cnt=0, internal registers=0. Applies mid-operation; the partial result is discarded.
- IDLE:
  - ready_o=0, result_o=0.
  - If start_i=1 and annul_i=0:
    - If opdata2_i==0: go to BYZERO.
    - Otherwise go to ON: latch |opdata1| and |opdata2| (magnitudes only when signed_div_i=1 and the MSB is set; raw values otherwise), latch signed_div_i and both operand sign bits, cnt=0, partial remainder=0.
- BYZERO: next edge goes to END with result=0 (remainder=0, quotient=0).
- ON (one iteration per edge):
  - Shift {rem, quo} left 1, bringing the next dividend MSB into rem.
  - Trial subtraction: diff = rem_shifted - divisor, computed W+1 bits wide.
  - If diff is non-negative: rem=diff[W-1:0] and the quotient LSB = 1; otherwise rem is kept and the quotient LSB = 0.
  - cnt increments. After WIDTH iterations (cnt==WIDTH), the next edge applies sign correction, registers result_o and goes to END.
  - start_i is ignored while in ON (the initiator must not drop it).
- Sign correction (signed only):
  - quotient negated iff dividend sign XOR divisor sign.
  - remainder negated iff dividend sign set.
  - Unsigned: no correction.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000 (wraps), remainder=0. No exception is raised.
- END:
  - ready_o=1; result_o is held.
  - When start_i=0 or annul_i=1: go to IDLE with ready_o=0 and result_o=0.
  - While start_i stays 1, the block remains in END and no new request is accepted.
- Latency, counting from the edge that samples start_i=1 in IDLE (edge 0):
  - Nonzero divisor: ready_o first high after edge WIDTH+1 (33 for W=32).
  - Zero divisor: ready_o high after edge 2.
- annul_i:
  - In BYZERO, ON or END: annul_i=1 at an edge forces IDLE with ready_o=0 and result_o=0; the result is never presented.
  - In IDLE: annul_i=1 blocks acceptance even with start_i=1.
  - annul_i takes priority over start_i.
- A new request may be accepted on the edge after END returns to IDLE, i.e. the minimum spacing is one idle cycle.
- There is no back-to-back acceptance from END.

Test Plan:
- DIVU 100/7: start_i=1 held. Required: ready_o rises exactly 33 cycles after acceptance, result_o={32'd2, 32'd14}. Drop start_i: next edge ready_o=0 and result_o=0.
- DIV -7/2 (0xFFFFFFF9 / 2): required quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Also DIV 7/-2: quotient -3, remainder +1.
- Divide by zero (any dividend / 0, signed and unsigned): required ready_o after 2 cycles, result_o=0. Also DIV 0x80000000 / 0xFFFFFFFF: required quotient 0x80000000, remainder 0.
- Annul: assert annul_i for one cycle at iteration 10 of DIVU 0xFFFFFFFF/3. Required: IDLE on the following edge, ready_o never high. A fresh request for 9/3 then gives {0,3} after 33 cycles.
- Reset mid-operation: rst=0 for one edge at iteration 20. Required: ready_o=0 and result_o=0 after that edge. A subsequent DIVU 0xFFFFFFFF/0xFFFFFFFF gives {0,1}.
- Hold in END: keep start_i=1 for 5 cycles after ready_o. Required: result_o stable, no re-start. annul_i in IDLE with start_i=1 must not be accepted.
